// File: rtl/piece_queue_if.sv
// piece_queue_if: game-control side of the piece queue
// master: the queue (takes flush/run/random/piece_ready, drives head/preview/status)
// slave : the consumer (drives flush/run/random/piece_ready, takes head/preview/status)
interface piece_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          flush;
  logic          run;
  logic [1:0]    random;
  logic          piece_ready;
  logic          piece_valid;
  logic [1:0]    piece_out;
  logic          next_valid;
  logic [1:0]    next_piece;
  logic [CW-1:0] count;
  logic          full;
  modport master (
    input  flush, run, random, piece_ready,
    output piece_valid, piece_out, next_valid, next_piece, count, full
  );
  modport slave (
    output flush, run, random, piece_ready,
    input  piece_valid, piece_out, next_valid, next_piece, count, full
  );
endinterface

// File: rtl/piece_queue.sv
// piece_queue: buffers sampled random pieces in a FIFO with preview and optional no-repeat
// clka/restart_n: clock and async active-low reset
// bus (master): flush/run/random/piece_ready in; piece_valid/piece_out, next_valid/next_piece, count, full out
module piece_queue #(
  parameter int DEPTH     = 4,
  parameter bit NO_REPEAT = 1
) (
  input logic         clka,
  input logic         restart_n,
  piece_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
  state_t                  state_q, state_d;
  logic [DEPTH-1:0][1:0]   mem_q, mem_d;
  logic [AW-1:0]           rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [1:0]              last_piece_q, last_piece_d;
  logic                    last_valid_q, last_valid_d;
  logic                    pop, push;
  logic [1:0]              sample;
  always_comb begin
    pop          = (state_q != EMPTY) & bus.piece_ready;
    push         = bus.run & ((state_q != FULL) | pop);
    // a repeat of the previous stored piece is bumped to the next index, wrapping 3 -> 0
    sample       = (NO_REPEAT && last_valid_q && bus.random == last_piece_q) ? bus.random + 2'd1 : bus.random;
    mem_d        = mem_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    count_d      = count_q;
    last_piece_d = last_piece_q;
    last_valid_d = last_valid_q;
    if (bus.flush) begin
      rd_d         = '0;
      wr_d         = '0;
      count_d      = '0;
      last_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_q]  = sample;
        wr_d         = wr_q + AW'(1);
        last_piece_d = sample;
        last_valid_d = 1'b1;
      end
      if (pop) rd_d = rd_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
    state_d = (count_d == '0) ? EMPTY : (count_d == CW'(DEPTH)) ? FULL : PARTIAL;
  end
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q      <= EMPTY;
      mem_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      last_piece_q <= '0;
      last_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      last_piece_q <= last_piece_d;
      last_valid_q <= last_valid_d;
    end
  end
  logic head_valid, second_valid;
  assign head_valid      = state_q != EMPTY;
  assign second_valid    = count_q >= CW'(2);
  assign bus.piece_valid = head_valid;
  assign bus.piece_out   = head_valid ? mem_q[rd_q] : 2'd0;
  assign bus.next_valid  = second_valid;
  assign bus.next_piece  = second_valid ? mem_q[rd_q + AW'(1)] : 2'd0;
  assign bus.count       = count_q;
  assign bus.full        = state_q == FULL;
endmodule

// File: tb/tb_piece_queue.sv
// tb_piece_queue: directed checks of piece_queue with DEPTH=4, NO_REPEAT=1
module tb_piece_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  piece_queue_if #(.DEPTH(4)) pq ();
  piece_queue #(.DEPTH(4), .NO_REPEAT(1)) dut (
    .clka      (clk),
    .restart_n (rst_n),
    .bus       (pq.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask
  initial begin
    pq.flush = 1'b0;
    pq.run = 1'b0;
    pq.random = 2'd0;
    pq.piece_ready = 1'b0;
    #1;
    check("rst_count", int'(pq.count), 0);
    check("rst_valid", int'(pq.piece_valid), 0);
    check("rst_out", int'(pq.piece_out), 0);
    check("rst_nvalid", int'(pq.next_valid), 0);
    check("rst_next", int'(pq.next_piece), 0);
    check("rst_full", int'(pq.full), 0);
    #7 rst_n = 1'b1;
    pq.run = 1'b1;
    pq.random = 2'd2;
    step();
    check("t1_lat_valid", int'(pq.piece_valid), 1);
    check("t1_lat_out", int'(pq.piece_out), 2);
    check("t1_lat_count", int'(pq.count), 1);
    check("t1_lat_nvalid", int'(pq.next_valid), 0);
    step();
    step();
    step();
    check("t1_full", int'(pq.full), 1);
    check("t1_count", int'(pq.count), 4);
    check("t1_out", int'(pq.piece_out), 2);
    check("t1_next", int'(pq.next_piece), 3);
    step();
    check("t1_hold_count", int'(pq.count), 4);
    check("t1_hold_out", int'(pq.piece_out), 2);
    pq.run = 1'b0;
    do_reset();
    pq.run = 1'b1;
    pq.random = 2'd3;
    step();
    step();
    pq.run = 1'b0;
    check("t2_out", int'(pq.piece_out), 3);
    check("t2_next", int'(pq.next_piece), 0);
    check("t2_count", int'(pq.count), 2);
    check("t2_full", int'(pq.full), 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_count", int'(pq.count), 0);
    check("arst_valid", int'(pq.piece_valid), 0);
    check("arst_out", int'(pq.piece_out), 0);
    check("arst_nvalid", int'(pq.next_valid), 0);
    #1 rst_n = 1'b1;
    pq.run = 1'b1;
    pq.random = 2'd1;
    step();
    check("arst_push_valid", int'(pq.piece_valid), 1);
    check("arst_push_out", int'(pq.piece_out), 1);
    check("arst_push_count", int'(pq.count), 1);
    pq.run = 1'b0;
    do_reset();
    pq.run = 1'b1;
    pq.random = 2'd1;
    step();
    pq.random = 2'd2;
    step();
    pq.random = 2'd3;
    step();
    pq.random = 2'd0;
    step();
    check("t3_fill_count", int'(pq.count), 4);
    check("t3_fill_out", int'(pq.piece_out), 1);
    pq.random = 2'd1;
    pq.piece_ready = 1'b1;
    step();
    check("t3_pp_count", int'(pq.count), 4);
    check("t3_pp_full", int'(pq.full), 1);
    check("t3_pp_out", int'(pq.piece_out), 2);
    check("t3_pp_next", int'(pq.next_piece), 3);
    pq.run = 1'b0;
    step();
    check("t3_drain1_out", int'(pq.piece_out), 3);
    step();
    step();
    check("t3_tail_out", int'(pq.piece_out), 1);
    check("t3_tail_count", int'(pq.count), 1);
    check("t3_tail_nvalid", int'(pq.next_valid), 0);
    step();
    check("t4_valid", int'(pq.piece_valid), 0);
    check("t4_out", int'(pq.piece_out), 0);
    check("t4_count", int'(pq.count), 0);
    step();
    step();
    check("t4_empty_pop", int'(pq.count), 0);
    pq.piece_ready = 1'b0;
    pq.run = 1'b1;
    pq.random = 2'd2;
    step();
    step();
    step();
    check("t5_count", int'(pq.count), 3);
    check("t5_out", int'(pq.piece_out), 2);
    check("t5_next", int'(pq.next_piece), 3);
    pq.flush = 1'b1;
    pq.piece_ready = 1'b1;
    step();
    check("t5_flush_count", int'(pq.count), 0);
    check("t5_flush_valid", int'(pq.piece_valid), 0);
    pq.flush = 1'b0;
    pq.piece_ready = 1'b0;
    step();
    check("t5_first_valid", int'(pq.piece_valid), 1);
    check("t5_first_out", int'(pq.piece_out), 2);
    step();
    check("t5_second_next", int'(pq.next_piece), 3);
    check("t5_second_count", int'(pq.count), 2);
    pq.run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
